// File: rtl/midi_msg_assembler.sv
// Assembles MIDI channel-voice messages with running status; real-time bytes pass through, SysEx and orphan data are dropped.
// One-cycle registered latency, no backpressure; optional channel filter enabled by defining MIDI_CHAN_FILTER_EN.
module midi_msg_assembler #(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic [3:0]            filt_chan,
  output logic                  msg_valid,
  output logic [7:0]            msg_status,
  output logic [6:0]            msg_d1,
  output logic [6:0]            msg_d2,
  output logic                  rt_valid,
  output logic [7:0]            rt_byte,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} stateT;

  stateT      state;
  logic [7:0] runStatus;
  logic [6:0] d1Latch;
  logic       oneByteType;
  logic       chanMatch;

  // Program change and channel pressure carry a single data byte.
  assign oneByteType = (runStatus[7:4] == 4'hC) || (runStatus[7:4] == 4'hD);

`ifdef MIDI_CHAN_FILTER_EN
  assign chanMatch = (runStatus[3:0] == filt_chan);
`else
  logic unusedFiltChan;
  assign unusedFiltChan = ^filt_chan;
  assign chanMatch      = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      runStatus  <= '0;
      d1Latch    <= '0;
      msg_valid  <= 1'b0;
      msg_status <= '0;
      msg_d1     <= '0;
      msg_d2     <= '0;
      rt_valid   <= 1'b0;
      rt_byte    <= '0;
      drop_cnt   <= '0;
    end else begin
      msg_valid <= 1'b0;
      rt_valid  <= 1'b0;
      if (in_valid) begin
        if (in_data >= 8'hF8) begin
          // Real-time bytes leave parser state untouched.
          rt_valid <= 1'b1;
          rt_byte  <= in_data;
        end else if (!in_data[7]) begin
          case (state)
            WAIT_D1: begin
              if (oneByteType) begin
                if (chanMatch) begin
                  msg_valid  <= 1'b1;
                  msg_status <= runStatus;
                  msg_d1     <= in_data[6:0];
                  msg_d2     <= '0;
                end
              end else begin
                d1Latch <= in_data[6:0];
                state   <= WAIT_D2;
              end
            end
            WAIT_D2: begin
              if (chanMatch) begin
                msg_valid  <= 1'b1;
                msg_status <= runStatus;
                msg_d1     <= d1Latch;
                msg_d2     <= in_data[6:0];
              end
              state <= WAIT_D1;
            end
            default: begin
              if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
          endcase
        end else if (in_data < 8'hF0) begin
          runStatus <= in_data;
          state     <= WAIT_D1;
        end else if (in_data == 8'hF0) begin
          runStatus <= '0;
          state     <= SYSEX;
        end else begin
          runStatus <= '0;
          state     <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_assembler.sv
// Randomized and directed bench for midi_msg_assembler against a queue-based message model.
module tb_midi_msg_assembler;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic [3:0]    filt_chan;
  logic          msg_valid;
  logic [7:0]    msg_status;
  logic [6:0]    msg_d1;
  logic [6:0]    msg_d2;
  logic          rt_valid;
  logic [7:0]    rt_byte;
  logic [DW-1:0] drop_cnt;

  midi_msg_assembler #(.DROP_CNT_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .filt_chan(filt_chan),
    .msg_valid(msg_valid), .msg_status(msg_status), .msg_d1(msg_d1), .msg_d2(msg_d2),
    .rt_valid(rt_valid), .rt_byte(rt_byte), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int testCnt = 0;
  int failCnt = 0;

  // Reference model: current running status (0 = none) and the data bytes gathered so far.
  logic [7:0]    mRun;
  logic [6:0]    mPend[$];
  logic          eMsgVld;
  logic [7:0]    eStatus;
  logic [6:0]    eD1;
  logic [6:0]    eD2;
  logic          eRtVld;
  logic [7:0]    eRt;
  logic [DW-1:0] eDrop;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelByte(input logic [7:0] b);
    int need;
    bit emit;
    if (b >= 8'hF8) begin
      eRtVld = 1'b1;
      eRt    = b;
    end else if (b < 8'h80) begin
      if (mRun == 8'h00) begin
        if (eDrop != {DW{1'b1}}) eDrop = eDrop + 1'b1;
      end else begin
        mPend.push_back(b[6:0]);
        need = (mRun[7:4] == 4'hC || mRun[7:4] == 4'hD) ? 1 : 2;
        if (mPend.size() == need) begin
`ifdef MIDI_CHAN_FILTER_EN
          emit = (mRun[3:0] == filt_chan);
`else
          emit = 1'b1;
`endif
          if (emit) begin
            eMsgVld = 1'b1;
            eStatus = mRun;
            eD1     = mPend[0];
            eD2     = (need == 2) ? mPend[1] : 7'h00;
          end
          mPend.delete();
        end
      end
    end else if (b < 8'hF0) begin
      mRun = b;
      mPend.delete();
    end else begin
      mRun = 8'h00;
      mPend.delete();
    end
  endtask

  // Called at a negedge: drive one cycle of input, advance the model, check at the next negedge.
  task automatic step(input bit v, input logic [7:0] b, input bit rst);
    rst_n    = !rst;
    in_valid = v;
    in_data  = b;
    eMsgVld  = 1'b0;
    eRtVld   = 1'b0;
    if (rst) begin
      mRun = 8'h00; mPend.delete();
      eStatus = '0; eD1 = '0; eD2 = '0; eRt = '0; eDrop = '0;
    end else if (v) begin
      modelByte(b);
    end
    @(negedge clk);
    checkVal("msg_valid", msg_valid, eMsgVld);
    checkVal("msg_status", msg_status, eStatus);
    checkVal("msg_d1", msg_d1, eD1);
    checkVal("msg_d2", msg_d2, eD2);
    checkVal("rt_valid", rt_valid, eRtVld);
    checkVal("rt_byte", rt_byte, eRt);
    checkVal("drop_cnt", drop_cnt, eDrop);
  endtask

  task automatic sendGap(input logic [7:0] b, input int gap);
    step(1'b1, b, 1'b0);
    repeat (gap - 1) step(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic doReset();
    repeat (2) step(1'b0, 8'h00, 1'b1);
  endtask

  function automatic logic [7:0] randByte();
    int r = $urandom_range(0, 99);
    if (r < 55)      return 8'($urandom_range(0, 127));
    else if (r < 78) return {4'($urandom_range(8, 14)),
                             ($urandom_range(0, 1) != 0) ? filt_chan : 4'($urandom_range(0, 15))};
    else if (r < 88) return 8'($urandom_range(248, 255));
    else if (r < 93) return 8'hF0;
    else             return 8'($urandom_range(241, 247));
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; filt_chan = 4'd0;
    doReset();
    checkVal("reset_msg_valid", msg_valid, 0);
    checkVal("reset_drop_cnt", drop_cnt, 0);

    // Note-on at the crossing-stage strobe rate.
    sendGap(8'h90, 29); sendGap(8'h3C, 29);
    step(1'b1, 8'h64, 1'b0);
    checkVal("t1_vld", msg_valid, 1);
    checkVal("t1_status", msg_status, 8'h90);
    checkVal("t1_d1", msg_d1, 7'h3C);
    checkVal("t1_d2", msg_d2, 7'h64);
    checkVal("t1_drop", drop_cnt, 0);
    step(1'b0, 8'h00, 1'b0);
    checkVal("t1_pulse_end", msg_valid, 0);

    // Running status continuation, velocity-0 note-on reported unchanged.
    sendGap(8'h40, 3);
    step(1'b1, 8'h00, 1'b0);
    checkVal("t2_vld", msg_valid, 1);
    checkVal("t2_status", msg_status, 8'h90);
    checkVal("t2_d1", msg_d1, 7'h40);
    checkVal("t2_d2", msg_d2, 7'h00);

    // One-data-byte type with back-to-back strobes.
    filt_chan = 4'd5;
    step(1'b1, 8'hC5, 1'b0);
    step(1'b1, 8'h07, 1'b0);
    checkVal("t3_vld_a", msg_valid, 1);
    checkVal("t3_d1_a", msg_d1, 7'h07);
    checkVal("t3_d2_a", msg_d2, 7'h00);
    step(1'b1, 8'h08, 1'b0);
    checkVal("t3_vld_b", msg_valid, 1);
    checkVal("t3_status_b", msg_status, 8'hC5);
    checkVal("t3_d1_b", msg_d1, 7'h08);

    // Real-time byte in the middle of a message.
    filt_chan = 4'd0;
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'hF8, 1'b0);
    checkVal("t4_rt_vld", rt_valid, 1);
    checkVal("t4_rt_byte", rt_byte, 8'hF8);
    checkVal("t4_no_msg", msg_valid, 0);
    step(1'b1, 8'h00, 1'b0);
    checkVal("t4_vld", msg_valid, 1);
    checkVal("t4_status", msg_status, 8'h80);
    checkVal("t4_d1", msg_d1, 7'h3C);
    checkVal("t4_rt_end", rt_valid, 0);

    // SysEx, system common and orphan data bytes.
    doReset();
    sendGap(8'h12, 2); sendGap(8'hF0, 2); sendGap(8'h41, 2);
    sendGap(8'h10, 2); sendGap(8'hF7, 2); sendGap(8'h55, 2);
    checkVal("t5_drop", drop_cnt, 4);
    checkVal("t5_no_msg_status", msg_status, 0);
    // Abandoned partial message, then continuation under the new status.
    sendGap(8'h90, 2); sendGap(8'h3C, 2); sendGap(8'hB0, 2);
    checkVal("t5_abandon_no_msg", msg_valid, 0);
    checkVal("t5_abandon_drop", drop_cnt, 4);
    sendGap(8'h01, 1);
    step(1'b1, 8'h02, 1'b0);
    checkVal("t5_cc_status", msg_status, 8'hB0);
    checkVal("t5_cc_d1", msg_d1, 7'h01);
    checkVal("t5_cc_d2", msg_d2, 7'h02);
    // Reset in the middle of a message clears everything.
    step(1'b1, 8'h90, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    checkVal("t5_rst_status", msg_status, 0);
    checkVal("t5_rst_drop", drop_cnt, 0);
    step(1'b1, 8'h64, 1'b0);
    checkVal("t5_rst_no_msg", msg_valid, 0);
    checkVal("t5_rst_orphan", drop_cnt, 1);

    // Channel filter.
    doReset();
    filt_chan = 4'd2;
    step(1'b1, 8'h91, 1'b0); step(1'b1, 8'h3C, 1'b0); step(1'b1, 8'h64, 1'b0);
`ifdef MIDI_CHAN_FILTER_EN
    checkVal("t6_filtered_vld", msg_valid, 0);
    checkVal("t6_filtered_status", msg_status, 0);
`else
    checkVal("t6_unfiltered_vld", msg_valid, 1);
    checkVal("t6_unfiltered_status", msg_status, 8'h91);
`endif
    step(1'b1, 8'h92, 1'b0); step(1'b1, 8'h3C, 1'b0); step(1'b1, 8'h64, 1'b0);
    checkVal("t6_pass_vld", msg_valid, 1);
    checkVal("t6_pass_status", msg_status, 8'h92);

    // Drop counter saturation.
    doReset();
    step(1'b1, 8'hF0, 1'b0);
    repeat (300) step(1'b1, 8'($urandom_range(0, 127)), 1'b0);
    checkVal("sat_drop", drop_cnt, 8'hFF);

    // Randomized traffic.
    doReset();
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 199) == 0) filt_chan = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0)      step(1'b0, 8'($urandom), 1'b1);
      else if ($urandom_range(0, 9) < 7)    step(1'b1, randByte(), 1'b0);
      else                                  step(1'b0, 8'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
